mem_resp_router: RTL and testbench
==================================

// Module: mem_resp_router
// PURPOSE
//   Response-side counterpart of the 2-to-1 fixed-priority address arbiter. Sits between
//   memory and the two requesters (port 0 has priority at the arbiter).
//   Records the winning source of every issued request in an in-order tag FIFO.
//   Steers each in-order memory response back to the requester that issued it.
//   Backpressures the arbiter when DEPTH requests are outstanding.
// PARAMETERS
//   DEPTH   4   max outstanding requests (tag FIFO entries); power of 2, >=2
//   DATA_W  32  response data width
//   CNT_W   $clog2(DEPTH)+1   derived; width of occupancy count
// PORTS
//   clock               in   1       single clock, all state on posedge
//   reset               in   1       synchronous, active-high
//   io_req_valid        in   1       arbiter issued a request this cycle
//   io_req_src          in   1       granted requester index (0/1)
//   io_req_ready        out  1       tag slot free; arbiter must hold request when low
//   io_resp_valid       in   1       memory response present
//   io_resp_ready       out  1       response consumed this cycle
//   io_resp_bits_data   in   DATA_W  response data
//   io_out_0_valid      out  1       response for requester 0
//   io_out_0_ready      in   1       requester 0 accepts
//   io_out_0_bits_data  out  DATA_W  response data to requester 0
//   io_out_1_valid      out  1       response for requester 1
//   io_out_1_ready      in   1       requester 1 accepts
//   io_out_1_bits_data  out  DATA_W  response data to requester 1
//   io_outstanding      out  CNT_W   current tag FIFO occupancy
//   io_err              out  1       sticky: orphan response seen (response with FIFO empty)
// BEHAVIOUR
//   State: tag[DEPTH] (1b each), wptr/rptr ($clog2(DEPTH)b, wrap mod DEPTH), count (CNT_W), err.
//   Reset (sync): wptr=rptr=0, count=0, err=0.
//     Outputs after reset: io_req_ready=1, io_outstanding=0, io_err=0, out valids=0.
//   full = (count==DEPTH); empty = (count==0); head = tag[rptr].
//   io_req_ready = !full. It is registered-state only, with no same-cycle dequeue bypass.
//     When full, ready=0 even if a response retires that cycle.
//   enq = io_req_valid & io_req_ready: tag[wptr]<=io_req_src, wptr<=wptr+1.
//   Routing is combinational, with zero latency:
//     io_out_k_valid = io_resp_valid & !empty & (head==k).
//   io_out_0_bits_data = io_out_1_bits_data = io_resp_bits_data. Data is don't-care when valid=0.
//   io_resp_ready = empty ? 1 : (head ? io_out_1_ready : io_out_0_ready).
//   deq = io_resp_valid & io_resp_ready & !empty: rptr<=rptr+1.
//   Orphan = io_resp_valid & empty. The response is dropped (ready=1, no out valid) and err<=1.
//     There is no empty bypass: a same-cycle enq does not match that response.
//   count <= count + enq - deq. Simultaneous enq and deq leaves count unchanged; both pointers advance.
//   No combinational path from io_out_k_ready to io_req_ready.
//     There is also no path from io_resp_valid to io_req_ready.
//   Invariant: count never exceeds DEPTH and never underflows.
//     An orphan response never decrements count.
//   Reset mid-operation discards all outstanding tags. A later response is then an orphan and sets err.
//   io_err clears only on reset.
// TESTING
//   T1 reset: assert reset 2 cycles with req/resp idle.
//      -> req_ready=1, outstanding=0, err=0, both out valids 0.
//   T2 routing: issue src 0,1,1 back-to-back, then 3 responses with data A0,B1,C2 and both outs ready.
//      -> out_0 gets A0, out_1 gets B1, then out_1 gets C2.
//      -> outstanding goes 1,2,3 then 2,1,0.
//   T3 backpressure: issue DEPTH=4 requests with no responses.
//      -> req_ready=0, outstanding=4.
//      -> In the cycle one response retires, req_ready stays 0; it is 1 next cycle with outstanding=3.
//   T4 stall: head src=1, resp_valid=1, out_1_ready=0 for 3 cycles.
//      -> resp_ready=0, out_1_valid=1 held, out_0_valid=0, rptr unchanged.
//      -> Raise out_1_ready: response retires in one cycle.
//   T5 simultaneous: outstanding=2; enq(src 0) and deq in the same cycle.
//      -> outstanding stays 2; the new tag is routed in order after the existing ones.
//   T6 orphan: resp_valid=1 with outstanding=0 (same cycle as a req enq).
//      -> resp_ready=1, no out valid, err=1 sticky; outstanding=1 next cycle.
//      -> err=0 only after reset.

Source files
------------

// File: rtl/mem_resp_router.sv
// Response router for a 2-to-1 arbitrated memory port: remembers the granted source of
// each request in an in-order tag FIFO and steers every in-order response back to it.
module mem_resp_router #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_req_valid,
    input  logic              io_req_src,
    output logic              io_req_ready,
    input  logic              io_resp_valid,
    output logic              io_resp_ready,
    input  logic [DATA_W-1:0] io_resp_bits_data,
    output logic              io_out_0_valid,
    input  logic              io_out_0_ready,
    output logic [DATA_W-1:0] io_out_0_bits_data,
    output logic              io_out_1_valid,
    input  logic              io_out_1_ready,
    output logic [DATA_W-1:0] io_out_1_bits_data,
    output logic [CNT_W-1:0]  io_outstanding,
    output logic              io_err
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wptr_reg;
    logic [PTR_W-1:0] rptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             err_reg;
    logic             tag_reg [DEPTH];

    logic full;
    logic empty;
    logic head;
    logic enq;
    logic deq;
    logic orphan;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign head  = tag_reg[rptr_reg];

    // Ready depends only on registered occupancy, so no ready/valid path leaks back to the arbiter.
    assign io_req_ready = !full;
    assign enq          = io_req_valid && io_req_ready;

    assign io_out_0_valid     = io_resp_valid && !empty && !head;
    assign io_out_1_valid     = io_resp_valid && !empty && head;
    assign io_out_0_bits_data = io_resp_bits_data;
    assign io_out_1_bits_data = io_resp_bits_data;

    // With no tag outstanding the response is an orphan: swallow it so memory never stalls.
    assign io_resp_ready = empty ? 1'b1 : (head ? io_out_1_ready : io_out_0_ready);
    assign deq           = io_resp_valid && io_resp_ready && !empty;
    assign orphan        = io_resp_valid && empty;

    assign io_outstanding = count_reg;
    assign io_err         = err_reg;

    // Tag slots need no reset: a slot is only read after it has been written.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tag
            always_ff @(posedge clock) begin
                if (enq && (wptr_reg == PTR_W'(gi))) begin
                    tag_reg[gi] <= io_req_src;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (enq) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (deq) begin
                rptr_reg <= rptr_reg + 1'b1;
            end
            count_reg <= count_reg + CNT_W'(enq) - CNT_W'(deq);
            if (orphan) begin
                err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_resp_router.sv
// Directed bench for mem_resp_router: expected response data is queued per requester when a
// response is driven, and a negedge monitor pops and compares on every output handshake.
module tb_mem_resp_router;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_src;
    logic              req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              out0_valid;
    logic              out0_ready;
    logic [DATA_W-1:0] out0_data;
    logic              out1_valid;
    logic              out1_ready;
    logic [DATA_W-1:0] out1_data;
    logic [CNT_W-1:0]  outstanding;
    logic              err;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] exp0_q[$];
    logic [DATA_W-1:0] exp1_q[$];

    mem_resp_router #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clock              (clock),
        .reset              (reset),
        .io_req_valid       (req_valid),
        .io_req_src         (req_src),
        .io_req_ready       (req_ready),
        .io_resp_valid      (resp_valid),
        .io_resp_ready      (resp_ready),
        .io_resp_bits_data  (resp_data),
        .io_out_0_valid     (out0_valid),
        .io_out_0_ready     (out0_ready),
        .io_out_0_bits_data (out0_data),
        .io_out_1_valid     (out1_valid),
        .io_out_1_ready     (out1_ready),
        .io_out_1_bits_data (out1_data),
        .io_outstanding     (outstanding),
        .io_err             (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_resp(input logic [DATA_W-1:0] d, input int port);
        resp_valid = 1'b1;
        resp_data  = d;
        if (port == 0) exp0_q.push_back(d);
        else if (port == 1) exp1_q.push_back(d);
    endtask

    // Monitor: compares every accepted output beat against the per-port scoreboard.
    initial begin
        logic [DATA_W-1:0] e;
        forever begin
            @(negedge clock);
            if (out0_valid && out0_ready) begin
                if (exp0_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out0_unexpected: got %0h expected none", out0_data);
                end else begin
                    e = exp0_q.pop_front();
                    check("out0_data", out0_data, e);
                end
            end
            if (out1_valid && out1_ready) begin
                if (exp1_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out1_unexpected: got %0h expected none", out1_data);
                end else begin
                    e = exp1_q.pop_front();
                    check("out1_data", out1_data, e);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_src    = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;

        // T1: reset
        tick();
        tick();
        check("t1_req_ready", 32'(req_ready), 32'd1);
        check("t1_outstanding", 32'(outstanding), 32'd0);
        check("t1_err", 32'(err), 32'd0);
        check("t1_out0_valid", 32'(out0_valid), 32'd0);
        check("t1_out1_valid", 32'(out1_valid), 32'd0);
        reset = 1'b0;

        // T2: routing of src 0,1,1
        req_valid = 1'b1;
        req_src = 1'b0; tick(); check("t2_out_1", 32'(outstanding), 32'd1);
        req_src = 1'b1; tick(); check("t2_out_2", 32'(outstanding), 32'd2);
        req_src = 1'b1; tick(); check("t2_out_3", 32'(outstanding), 32'd3);
        req_valid = 1'b0;
        send_resp(32'hA0, 0);
        #1;
        check("t2_out0_valid", 32'(out0_valid), 32'd1);
        check("t2_out1_valid", 32'(out1_valid), 32'd0);
        tick(); check("t2_drain_2", 32'(outstanding), 32'd2);
        send_resp(32'hB1, 1);
        tick(); check("t2_drain_1", 32'(outstanding), 32'd1);
        send_resp(32'hC2, 1);
        tick(); check("t2_drain_0", 32'(outstanding), 32'd0);
        resp_valid = 1'b0;

        // T3: backpressure at DEPTH, FIFO holds 0,1,0,1
        req_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            req_src = 1'(i & 1);
            tick();
        end
        check("t3_full_ready", 32'(req_ready), 32'd0);
        check("t3_full_count", 32'(outstanding), 32'd4);
        req_src = 1'b0;
        send_resp(32'hD0, 0);
        #1;
        check("t3_ready_retire_cycle", 32'(req_ready), 32'd0);
        tick();
        resp_valid = 1'b0;
        check("t3_ready_after", 32'(req_ready), 32'd1);
        check("t3_count_after", 32'(outstanding), 32'd3);
        tick();
        req_valid = 1'b0;
        check("t3_refill", 32'(outstanding), 32'd4);

        // T4: stall on head src 1; FIFO holds 1,0,1,0
        out1_ready = 1'b0;
        send_resp(32'hE1, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_resp_ready", 32'(resp_ready), 32'd0);
            check("t4_out1_valid", 32'(out1_valid), 32'd1);
            check("t4_out0_valid", 32'(out0_valid), 32'd0);
            tick();
            check("t4_count_held", 32'(outstanding), 32'd4);
        end
        out1_ready = 1'b1;
        #1;
        check("t4_resp_ready_up", 32'(resp_ready), 32'd1);
        tick();
        check("t4_retired", 32'(outstanding), 32'd3);
        send_resp(32'hF0, 0);
        tick();
        check("t5_pre_count", 32'(outstanding), 32'd2);

        // T5: simultaneous enq(src 0) and deq; FIFO holds 1,0
        req_valid = 1'b1;
        req_src   = 1'b0;
        send_resp(32'h61, 1);
        tick();
        req_valid = 1'b0;
        check("t5_count_same", 32'(outstanding), 32'd2);
        send_resp(32'h70, 0);
        tick(); check("t5_drain_1", 32'(outstanding), 32'd1);
        send_resp(32'h80, 0);
        tick(); check("t5_drain_0", 32'(outstanding), 32'd0);
        resp_valid = 1'b0;

        // T6: orphan response in the same cycle as an enq
        req_valid = 1'b1;
        req_src   = 1'b1;
        send_resp(32'h99, -1);
        #1;
        check("t6_resp_ready", 32'(resp_ready), 32'd1);
        check("t6_out0_valid", 32'(out0_valid), 32'd0);
        check("t6_out1_valid", 32'(out1_valid), 32'd0);
        check("t6_err_before", 32'(err), 32'd0);
        tick();
        req_valid  = 1'b0;
        resp_valid = 1'b0;
        check("t6_err_set", 32'(err), 32'd1);
        check("t6_count", 32'(outstanding), 32'd1);
        tick();
        check("t6_err_sticky", 32'(err), 32'd1);
        send_resp(32'hAA, 1);
        tick();
        resp_valid = 1'b0;
        check("t6_count_0", 32'(outstanding), 32'd0);
        check("t6_err_still", 32'(err), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_err_cleared", 32'(err), 32'd0);

        // Reset mid-operation discards the tag; the later response is an orphan
        req_valid = 1'b1;
        req_src   = 1'b0;
        tick();
        req_valid = 1'b0;
        check("rst_mid_count", 32'(outstanding), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_cleared", 32'(outstanding), 32'd0);
        send_resp(32'hBB, -1);
        #1;
        check("rst_mid_out0_valid", 32'(out0_valid), 32'd0);
        tick();
        resp_valid = 1'b0;
        check("rst_mid_err", 32'(err), 32'd1);
        check("rst_mid_count0", 32'(outstanding), 32'd0);

        tick();
        tick();
        check("sb_exp0_empty", 32'(exp0_q.size()), 32'd0);
        check("sb_exp1_empty", 32'(exp1_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
